// File: rtl/toe_cam_pkg.sv
// rtl/toe_cam_pkg.sv - shared constants, encodings and FSM state for the TOE session CAM controller
package toe_cam_pkg;
    localparam int K     = 97;
    localparam int V     = 14;
    localparam int N     = 4;
    localparam int A     = 2;
    localparam int D     = 115;
    localparam int VALID = 113;

    typedef enum logic [1:0] {
        STATUS_NEW       = 2'd0,
        STATUS_REPLACED  = 2'd1,
        STATUS_NOT_FOUND = 2'd2,
        STATUS_FULL      = 2'd3
    } status_t;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } op_t;

    typedef enum logic {
        SRC_LKP = 1'b0,
        SRC_UPD = 1'b1
    } src_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    function automatic logic [D-1:0] makeEntry(input logic [K-1:0] key, input logic [V-1:0] value);
        logic [D-1:0] w;
        w          = '0;
        w[VALID]   = 1'b1;
        w[K+V-1:K] = value;
        w[K-1:0]   = key;
        return w;
    endfunction
endpackage

// File: rtl/toe_cam_free_enc.sv
// rtl/toe_cam_free_enc.sv - lowest-free-slot priority encoder over the shadow valid bitmap
module toe_cam_free_enc
    import toe_cam_pkg::*;
(
    input  logic [N-1:0] ValidMap,
    output logic         Full,
    output logic [A-1:0] Addr
);
    always_comb begin
        Full = &ValidMap;
        Addr = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!ValidMap[i]) Addr = A'(i);
        end
    end
endmodule

// File: rtl/toe_cam_ctrl.sv
// rtl/toe_cam_ctrl.sv - arbiter/controller sharing the TOE session CAM between lookup and update clients
module toe_cam_ctrl
    import toe_cam_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         LkpReqValid,
    output logic         LkpReqReady,
    input  logic [K-1:0] LkpReqKey,
    output logic         LkpRspValid,
    input  logic         LkpRspReady,
    output logic         LkpRspHit,
    output logic [V-1:0] LkpRspValue,
    input  logic         UpdReqValid,
    output logic         UpdReqReady,
    input  logic         UpdReqOp,
    input  logic [K-1:0] UpdReqKey,
    input  logic [V-1:0] UpdReqValue,
    output logic         UpdRspValid,
    input  logic         UpdRspReady,
    output logic [1:0]   UpdRspStatus,
    output logic [A-1:0] UpdRspAddr,
    output logic [A:0]   UsedCount,
    output logic         Busy,
    output logic         CamRamReq,
    output logic         CamRamOp,
    output logic [A-1:0] CamRamAddr,
    output logic [D-1:0] CamRamData,
    output logic         CamLookupReqValid,
    output logic [K-1:0] CamLookupReqKey,
    input  logic         CamLookupRespValid,
    input  logic         CamLookupRespHit,
    input  logic [A-1:0] CamLookupRespAddr,
    input  logic [V-1:0] CamLookupRespValue
);
    localparam logic [A:0] InitDone = (A+1)'(N);

    state_t       state;
    logic [A:0]   initCnt;
    logic [N-1:0] validMap;
    src_t         src;
    src_t         rr;
    op_t          op;
    logic [V-1:0] latValue;
    logic         freeFull;
    logic [A-1:0] freeAddr;
    logic         idle;

    toe_cam_free_enc uFreeEnc (
        .ValidMap(validMap),
        .Full    (freeFull),
        .Addr    (freeAddr)
    );

    // rr names the requester that wins the next tie
    assign idle        = (state == S_IDLE);
    assign LkpReqReady = idle & LkpReqValid & (~UpdReqValid | (rr == SRC_LKP));
    assign UpdReqReady = idle & UpdReqValid & (~LkpReqValid | (rr == SRC_UPD));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state             <= S_INIT;
            initCnt           <= '0;
            validMap          <= '0;
            UsedCount         <= '0;
            src               <= SRC_LKP;
            rr                <= SRC_LKP;
            op                <= OP_INSERT;
            latValue          <= '0;
            Busy              <= 1'b1;
            LkpRspValid       <= 1'b0;
            LkpRspHit         <= 1'b0;
            LkpRspValue       <= '0;
            UpdRspValid       <= 1'b0;
            UpdRspStatus      <= STATUS_NEW;
            UpdRspAddr        <= '0;
            CamRamReq         <= 1'b0;
            CamRamOp          <= 1'b0;
            CamRamAddr        <= '0;
            CamRamData        <= '0;
            CamLookupReqValid <= 1'b0;
            CamLookupReqKey   <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (initCnt == InitDone) begin
                        CamRamReq <= 1'b0;
                        CamRamOp  <= 1'b0;
                        Busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        CamRamReq  <= 1'b1;
                        CamRamOp   <= 1'b1;
                        CamRamAddr <= initCnt[A-1:0];
                        CamRamData <= '0;
                        initCnt    <= initCnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (LkpReqReady) begin
                        src               <= SRC_LKP;
                        rr                <= SRC_UPD;
                        op                <= OP_INSERT;
                        latValue          <= '0;
                        CamLookupReqKey   <= LkpReqKey;
                        CamLookupReqValid <= 1'b1;
                        state             <= S_ISSUE;
                    end else if (UpdReqReady) begin
                        src               <= SRC_UPD;
                        rr                <= SRC_LKP;
                        op                <= op_t'(UpdReqOp);
                        latValue          <= UpdReqValue;
                        CamLookupReqKey   <= UpdReqKey;
                        CamLookupReqValid <= 1'b1;
                        state             <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    CamLookupReqValid <= 1'b0;
                    state             <= S_WAIT;
                end
                S_WAIT: begin
                    if (CamLookupRespValid) begin
                        if (src == SRC_LKP) begin
                            LkpRspValid <= 1'b1;
                            LkpRspHit   <= CamLookupRespHit;
                            LkpRspValue <= CamLookupRespHit ? CamLookupRespValue : '0;
                            state       <= S_RESP;
                        end else if (CamLookupRespHit) begin
                            CamRamReq  <= 1'b1;
                            CamRamOp   <= 1'b1;
                            CamRamAddr <= CamLookupRespAddr;
                            UpdRspAddr <= CamLookupRespAddr;
                            if (op == OP_INSERT) begin
                                CamRamData   <= makeEntry(CamLookupReqKey, latValue);
                                UpdRspStatus <= STATUS_REPLACED;
                            end else begin
                                // Successful delete reports code 0
                                CamRamData                  <= '0;
                                UpdRspStatus                <= STATUS_NEW;
                                validMap[CamLookupRespAddr] <= 1'b0;
                                UsedCount                   <= UsedCount - 1'b1;
                            end
                            state <= S_WRITE;
                        end else if (op == OP_INSERT && !freeFull) begin
                            CamRamReq          <= 1'b1;
                            CamRamOp           <= 1'b1;
                            CamRamAddr         <= freeAddr;
                            CamRamData         <= makeEntry(CamLookupReqKey, latValue);
                            UpdRspAddr         <= freeAddr;
                            UpdRspStatus       <= STATUS_NEW;
                            validMap[freeAddr] <= 1'b1;
                            UsedCount          <= UsedCount + 1'b1;
                            state              <= S_WRITE;
                        end else begin
                            UpdRspValid  <= 1'b1;
                            UpdRspAddr   <= '0;
                            UpdRspStatus <= (op == OP_INSERT) ? STATUS_FULL : STATUS_NOT_FOUND;
                            state        <= S_RESP;
                        end
                    end
                end
                S_WRITE: begin
                    CamRamReq   <= 1'b0;
                    CamRamOp    <= 1'b0;
                    UpdRspValid <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if ((src == SRC_LKP) ? LkpRspReady : UpdRspReady) begin
                        LkpRspValid <= 1'b0;
                        UpdRspValid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_toe_cam_ctrl.sv
// tb/tb_toe_cam_ctrl.sv - directed self-checking bench for toe_cam_ctrl with a behavioural 2-cycle CAM
module tb_toe_cam_ctrl;
    import toe_cam_pkg::*;

    localparam logic [D-1:0] JUNK = {4'hF, 14'h3FFF, 97'h1234};

    logic         Clk = 1'b0;
    logic         Rst;
    logic         LkpReqValid, LkpReqReady, LkpRspValid, LkpRspReady, LkpRspHit;
    logic [K-1:0] LkpReqKey;
    logic [V-1:0] LkpRspValue;
    logic         UpdReqValid, UpdReqReady, UpdReqOp, UpdRspValid, UpdRspReady;
    logic [K-1:0] UpdReqKey;
    logic [V-1:0] UpdReqValue;
    logic [1:0]   UpdRspStatus;
    logic [A-1:0] UpdRspAddr;
    logic [A:0]   UsedCount;
    logic         Busy, CamRamReq, CamRamOp, CamLookupReqValid;
    logic [A-1:0] CamRamAddr;
    logic [D-1:0] CamRamData;
    logic [K-1:0] CamLookupReqKey;
    logic         CamLookupRespValid = 1'b0;
    logic         CamLookupRespHit   = 1'b0;
    logic [A-1:0] CamLookupRespAddr  = '0;
    logic [V-1:0] CamLookupRespValue = '0;

    int checks   = 0;
    int failures = 0;

    logic [D-1:0] camMem [N] = '{default: JUNK};
    logic         s1Valid = 1'b0;
    logic [K-1:0] s1Key   = '0;
    int           ramWrCnt = 0;
    logic [A-1:0] lastWrAddr = '0;
    logic [D-1:0] lastWrData = '0;
    int           grantLog[$];

    always #5 Clk = ~Clk;

    toe_cam_ctrl dut (
        .Clk(Clk), .Rst(Rst),
        .LkpReqValid(LkpReqValid), .LkpReqReady(LkpReqReady), .LkpReqKey(LkpReqKey),
        .LkpRspValid(LkpRspValid), .LkpRspReady(LkpRspReady), .LkpRspHit(LkpRspHit), .LkpRspValue(LkpRspValue),
        .UpdReqValid(UpdReqValid), .UpdReqReady(UpdReqReady), .UpdReqOp(UpdReqOp),
        .UpdReqKey(UpdReqKey), .UpdReqValue(UpdReqValue),
        .UpdRspValid(UpdRspValid), .UpdRspReady(UpdRspReady), .UpdRspStatus(UpdRspStatus), .UpdRspAddr(UpdRspAddr),
        .UsedCount(UsedCount), .Busy(Busy),
        .CamRamReq(CamRamReq), .CamRamOp(CamRamOp), .CamRamAddr(CamRamAddr), .CamRamData(CamRamData),
        .CamLookupReqValid(CamLookupReqValid), .CamLookupReqKey(CamLookupReqKey),
        .CamLookupRespValid(CamLookupRespValid), .CamLookupRespHit(CamLookupRespHit),
        .CamLookupRespAddr(CamLookupRespAddr), .CamLookupRespValue(CamLookupRespValue)
    );

    // CAM model: storage without reset, lookup answers two cycles after the request cycle
    always @(posedge Clk) begin
        logic         h;
        logic [A-1:0] ha;
        logic [V-1:0] hv;
        if (CamRamReq && CamRamOp) begin
            camMem[CamRamAddr] <= CamRamData;
            ramWrCnt           <= ramWrCnt + 1;
            lastWrAddr         <= CamRamAddr;
            lastWrData         <= CamRamData;
        end
        if (LkpReqReady) grantLog.push_back(0);
        if (UpdReqReady) grantLog.push_back(1);
        h  = 1'b0;
        ha = '0;
        hv = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (camMem[i][VALID] === 1'b1 && camMem[i][K-1:0] === s1Key) begin
                h  = 1'b1;
                ha = A'(i);
                hv = camMem[i][K+V-1:K];
            end
        end
        s1Valid            <= CamLookupReqValid;
        s1Key              <= CamLookupReqKey;
        CamLookupRespValid <= s1Valid;
        CamLookupRespHit   <= s1Valid & h;
        CamLookupRespAddr  <= ha;
        CamLookupRespValue <= hv;
    end

    function automatic logic [D-1:0] expWord(input logic [K-1:0] k, input logic [V-1:0] v);
        return {2'b01, 2'b00, v, k};
    endfunction

    task automatic do_lookup(input logic [K-1:0] k, output logic hit, output logic [V-1:0] val, output int lat);
        int guard;
        LkpReqValid = 1'b1;
        LkpReqKey   = k;
        #1;
        guard = 0;
        while (!LkpReqReady && guard < 100) begin
            @(posedge Clk); #1;
            guard++;
        end
        @(posedge Clk); #1;
        LkpReqValid = 1'b0;
        lat = 1;
        while (!LkpRspValid && lat < 100) begin
            @(posedge Clk); #1;
            lat++;
        end
        hit = LkpRspHit;
        val = LkpRspValue;
        @(posedge Clk); #1;
    endtask

    task automatic do_update(input logic del, input logic [K-1:0] k, input logic [V-1:0] v,
                             output logic [1:0] st, output logic [A-1:0] ad, output int lat, output int wrs);
        int guard;
        int wr0;
        wr0         = ramWrCnt;
        UpdReqValid = 1'b1;
        UpdReqOp    = del;
        UpdReqKey   = k;
        UpdReqValue = v;
        #1;
        guard = 0;
        while (!UpdReqReady && guard < 100) begin
            @(posedge Clk); #1;
            guard++;
        end
        @(posedge Clk); #1;
        UpdReqValid = 1'b0;
        lat = 1;
        while (!UpdRspValid && lat < 100) begin
            @(posedge Clk); #1;
            lat++;
        end
        st = UpdRspStatus;
        ad = UpdRspAddr;
        @(posedge Clk); #1;
        wrs = ramWrCnt - wr0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (CamRamReq !== 1'b0 || CamLookupReqValid !== 1'b0) begin failures++; $display("FAIL rst_cam got req=%b lkp=%b exp 0 0", CamRamReq, CamLookupReqValid); end
        checks++; if (UsedCount !== 3'd0) begin failures++; $display("FAIL rst_used got=%0d exp=0", UsedCount); end
        checks++; if (LkpRspValid !== 1'b0 || UpdRspValid !== 1'b0) begin failures++; $display("FAIL rst_rspvalid got=%b%b exp=00", LkpRspValid, UpdRspValid); end
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", Busy); end
        LkpReqValid = 1'b1;
        LkpReqKey   = 97'h1234;
        UpdReqValid = 1'b1;
        UpdReqOp    = 1'b1;
        UpdReqKey   = 97'h8888;
        Rst         = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(posedge Clk); #1;
            checks++;
            if (CamRamReq !== 1'b1 || CamRamOp !== 1'b1 || CamRamAddr !== A'(i) || CamRamData !== '0 || Busy !== 1'b1) begin
                failures++;
                $display("FAIL init_write%0d got req=%b op=%b addr=%0d data=%h busy=%b exp 1 1 %0d 0 1", i, CamRamReq, CamRamOp, CamRamAddr, CamRamData, Busy, i);
            end
            checks++;
            if (LkpReqReady !== 1'b0 || UpdReqReady !== 1'b0) begin
                failures++;
                $display("FAIL init_ready%0d got=%b%b exp=00", i, LkpReqReady, UpdReqReady);
            end
        end
        LkpReqValid = 1'b0;
        UpdReqValid = 1'b0;
        @(posedge Clk); #1;
        checks++; if (Busy !== 1'b0 || CamRamReq !== 1'b0) begin failures++; $display("FAIL init_done got busy=%b req=%b exp 0 0", Busy, CamRamReq); end
    endtask

    task automatic test_insert_lookup();
        logic [1:0] st; logic [A-1:0] ad; int lat, wrs; logic h; logic [V-1:0] v;
        do_update(1'b0, 97'h1234, 14'h0AB, st, ad, lat, wrs);
        checks++; if (st !== 2'd0 || ad !== 2'd0) begin failures++; $display("FAIL ins_new got st=%0d addr=%0d exp 0 0", st, ad); end
        checks++; if (lat !== 5 || wrs !== 1) begin failures++; $display("FAIL ins_timing got lat=%0d wrs=%0d exp 5 1", lat, wrs); end
        checks++; if (lastWrAddr !== 2'd0 || lastWrData !== expWord(97'h1234, 14'h0AB)) begin failures++; $display("FAIL ins_word got addr=%0d data=%h exp 0 %h", lastWrAddr, lastWrData, expWord(97'h1234, 14'h0AB)); end
        checks++; if (UsedCount !== 3'd1) begin failures++; $display("FAIL ins_used got=%0d exp=1", UsedCount); end
        do_lookup(97'h1234, h, v, lat);
        checks++; if (h !== 1'b1 || v !== 14'h0AB || lat !== 4) begin failures++; $display("FAIL lkp_hit got hit=%b val=%h lat=%0d exp 1 0ab 4", h, v, lat); end
        do_lookup(97'h9999, h, v, lat);
        checks++; if (h !== 1'b0 || v !== 14'h0 || lat !== 4) begin failures++; $display("FAIL lkp_miss got hit=%b val=%h lat=%0d exp 0 0 4", h, v, lat); end
    endtask

    task automatic test_replace();
        logic [1:0] st; logic [A-1:0] ad; int lat, wrs; logic h; logic [V-1:0] v;
        do_update(1'b0, 97'h1234, 14'h055, st, ad, lat, wrs);
        checks++; if (st !== 2'd1 || ad !== 2'd0 || wrs !== 1) begin failures++; $display("FAIL rep_status got st=%0d addr=%0d wrs=%0d exp 1 0 1", st, ad, wrs); end
        checks++; if (UsedCount !== 3'd1) begin failures++; $display("FAIL rep_used got=%0d exp=1", UsedCount); end
        do_lookup(97'h1234, h, v, lat);
        checks++; if (h !== 1'b1 || v !== 14'h055) begin failures++; $display("FAIL rep_lookup got hit=%b val=%h exp 1 055", h, v); end
    endtask

    task automatic test_full();
        logic [1:0] st; logic [A-1:0] ad; int lat, wrs;
        logic [K-1:0] keys [3];
        keys[0] = 97'h2000; keys[1] = 97'h3000; keys[2] = 97'h4000;
        for (int i = 0; i < 3; i++) begin
            do_update(1'b0, keys[i], 14'(i + 1), st, ad, lat, wrs);
            checks++; if (st !== 2'd0 || ad !== A'(i + 1)) begin failures++; $display("FAIL fill%0d got st=%0d addr=%0d exp 0 %0d", i, st, ad, i + 1); end
        end
        checks++; if (UsedCount !== 3'd4) begin failures++; $display("FAIL fill_used got=%0d exp=4", UsedCount); end
        do_update(1'b0, 97'h5000, 14'h5, st, ad, lat, wrs);
        checks++; if (st !== 2'd3 || ad !== 2'd0 || wrs !== 0 || lat !== 4) begin failures++; $display("FAIL full got st=%0d addr=%0d wrs=%0d lat=%0d exp 3 0 0 4", st, ad, wrs, lat); end
        do_update(1'b1, 97'h3000, 14'h0, st, ad, lat, wrs);
        checks++; if (st !== 2'd0 || ad !== 2'd2 || wrs !== 1 || lat !== 5) begin failures++; $display("FAIL del_hit got st=%0d addr=%0d wrs=%0d lat=%0d exp 0 2 1 5", st, ad, wrs, lat); end
        checks++; if (lastWrAddr !== 2'd2 || lastWrData !== '0 || UsedCount !== 3'd3) begin failures++; $display("FAIL del_write got addr=%0d data=%h used=%0d exp 2 0 3", lastWrAddr, lastWrData, UsedCount); end
        do_update(1'b0, 97'h6000, 14'h7, st, ad, lat, wrs);
        checks++; if (st !== 2'd0 || ad !== 2'd2 || UsedCount !== 3'd4) begin failures++; $display("FAIL reuse got st=%0d addr=%0d used=%0d exp 0 2 4", st, ad, UsedCount); end
        do_update(1'b1, 97'h7777, 14'h0, st, ad, lat, wrs);
        checks++; if (st !== 2'd2 || ad !== 2'd0 || wrs !== 0 || lat !== 4 || UsedCount !== 3'd4) begin failures++; $display("FAIL del_miss got st=%0d addr=%0d wrs=%0d lat=%0d used=%0d exp 2 0 0 4 4", st, ad, wrs, lat, UsedCount); end
    endtask

    task automatic test_round_robin();
        int base;
        int guard;
        base        = grantLog.size();
        LkpReqKey   = 97'h1234;
        UpdReqOp    = 1'b1;
        UpdReqKey   = 97'h8888;
        LkpReqValid = 1'b1;
        UpdReqValid = 1'b1;
        guard       = 0;
        while (grantLog.size() < base + 4 && guard < 200) begin
            @(posedge Clk); #1;
            guard++;
        end
        LkpReqValid = 1'b0;
        UpdReqValid = 1'b0;
        repeat (15) @(posedge Clk);
        #1;
        checks++;
        if (grantLog.size() < base + 4) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=4", grantLog.size() - base);
        end else if (grantLog[base] !== 0 || grantLog[base+1] !== 1 || grantLog[base+2] !== 0 || grantLog[base+3] !== 1) begin
            failures++;
            $display("FAIL rr_order got=%0d%0d%0d%0d exp=0101", grantLog[base], grantLog[base+1], grantLog[base+2], grantLog[base+3]);
        end
    endtask

    task automatic test_back_pressure();
        logic h; logic [V-1:0] v; int lat; int unstable; int grants;
        LkpRspReady = 1'b0;
        do_lookup(97'h1234, h, v, lat);
        checks++; if (h !== 1'b1 || v !== 14'h055 || lat !== 4) begin failures++; $display("FAIL bp_rsp got hit=%b val=%h lat=%0d exp 1 055 4", h, v, lat); end
        UpdReqValid = 1'b1;
        UpdReqOp    = 1'b1;
        UpdReqKey   = 97'h8888;
        unstable    = 0;
        grants      = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
            if (LkpRspValid !== 1'b1 || LkpRspHit !== 1'b1 || LkpRspValue !== 14'h055) unstable++;
            if (UpdReqReady !== 1'b0) grants++;
        end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_hold got unstable_cycles=%0d exp=0", unstable); end
        checks++; if (grants !== 0) begin failures++; $display("FAIL bp_nogrant got grants=%0d exp=0", grants); end
        UpdReqValid = 1'b0;
        LkpRspReady = 1'b1;
        @(posedge Clk); #1;
        checks++; if (LkpRspValid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", LkpRspValid); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] st; logic [A-1:0] ad; int lat, wrs; logic h; logic [V-1:0] v;
        int guard; int wr0; int rsps;
        UpdReqValid = 1'b1;
        UpdReqOp    = 1'b0;
        UpdReqKey   = 97'h9000;
        UpdReqValue = 14'h11;
        #1;
        guard = 0;
        while (!UpdReqReady && guard < 100) begin
            @(posedge Clk); #1;
            guard++;
        end
        @(posedge Clk); #1;
        UpdReqValid = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        #1;
        checks++; if (UsedCount !== 3'd0 || UpdRspValid !== 1'b0 || Busy !== 1'b1 || CamRamReq !== 1'b0) begin failures++; $display("FAIL midrst_state got used=%0d rsp=%b busy=%b req=%b exp 0 0 1 0", UsedCount, UpdRspValid, Busy, CamRamReq); end
        wr0 = ramWrCnt;
        @(posedge Clk); #1;
        Rst  = 1'b0;
        rsps = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (UpdRspValid === 1'b1) rsps++;
        end
        checks++; if (rsps !== 0) begin failures++; $display("FAIL midrst_norsp got=%0d exp=0", rsps); end
        checks++; if (ramWrCnt - wr0 !== 4 || lastWrAddr !== 2'd3 || lastWrData !== '0 || Busy !== 1'b0) begin failures++; $display("FAIL midrst_sweep got wrs=%0d addr=%0d busy=%b exp 4 3 0", ramWrCnt - wr0, lastWrAddr, Busy); end
        do_lookup(97'h1234, h, v, lat);
        checks++; if (h !== 1'b0 || v !== 14'h0) begin failures++; $display("FAIL midrst_cleared got hit=%b val=%h exp 0 0", h, v); end
        do_update(1'b0, 97'h9000, 14'h11, st, ad, lat, wrs);
        checks++; if (st !== 2'd0 || ad !== 2'd0 || UsedCount !== 3'd1) begin failures++; $display("FAIL midrst_insert got st=%0d addr=%0d used=%0d exp 0 0 1", st, ad, UsedCount); end
    endtask

    initial begin
        Rst         = 1'b1;
        LkpReqValid = 1'b0;
        LkpReqKey   = '0;
        LkpRspReady = 1'b1;
        UpdReqValid = 1'b0;
        UpdReqOp    = 1'b0;
        UpdReqKey   = '0;
        UpdReqValue = '0;
        UpdRspReady = 1'b1;
        test_reset();
        test_insert_lookup();
        test_replace();
        test_full();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
